// File: rtl/serial_adder.sv
// ============================================================================
// serial_adder : bit-serial full adder, LSB-first, one bit per clock.
// Revision 1.0
// ============================================================================
`default_nettype none

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int             CW     = $clog2(WIDTH + 1);
  localparam logic [1:0]     S_IDLE  = 2'd0;
  localparam logic [1:0]     S_SHIFT = 2'd1;
  localparam logic [1:0]     S_DONE  = 2'd2;
  localparam logic [CW-1:0]  C_LAST  = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             w_bit_s;
  logic             w_carry;
  logic             w_load;
  logic             w_last;
  logic [WIDTH-1:0] w_s_shift;

  assign w_bit_s = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
  assign w_carry = (a_sr_q[0] & b_sr_q[0]) | (c_q & (a_sr_q[0] ^ b_sr_q[0]));
  assign w_last  = (cnt_q == C_LAST);
  // Only start and the FSM state gate loading, so X operands never reach the FSM.
  assign w_load  = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  generate
    if (WIDTH == 1) begin : g_w1
      assign w_s_shift = w_bit_s;
    end else begin : g_wn
      assign w_s_shift = {w_bit_s, s_sr_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (w_last) state_d = S_DONE;
      S_DONE:  state_d = start ? S_SHIFT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_SHIFT);
    done = (state_q == S_DONE);
  end

  always_comb begin
    a_sr_d = a_sr_q;
    b_sr_d = b_sr_q;
    s_sr_d = s_sr_q;
    c_d    = c_q;
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    if (w_load) begin
      a_sr_d = a;
      b_sr_d = b;
      c_d    = cin;
      cnt_d  = '0;
      s_sr_d = '0;
    end else if (state_q == S_SHIFT) begin
      a_sr_d = a_sr_q >> 1;
      b_sr_d = b_sr_q >> 1;
      s_sr_d = w_s_shift;
      c_d    = w_carry;
      cnt_d  = cnt_q + CW'(1);
      if (w_last) begin
        sum_d  = w_s_shift;
        cout_d = w_carry;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_q <= '0;
      b_sr_q <= '0;
      s_sr_q <= '0;
      c_q    <= 1'b0;
      cnt_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      a_sr_q <= a_sr_d;
      b_sr_q <= b_sr_d;
      s_sr_q <= s_sr_d;
      c_q    <= c_d;
      cnt_q  <= cnt_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// tb_serial_adder : randomized self-checking bench for serial_adder (WIDTH 8 and 1).
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       cin;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic       s1_start, s1_a, s1_b, s1_cin;
  logic       s1_busy, s1_done, s1_sum, s1_cout;

  int         tests = 0;
  int         fails = 0;
  logic [8:0] prev_exp;
  logic [1:0] prev1;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1_start), .a(s1_a), .b(s1_b), .cin(s1_cin),
    .busy(s1_busy), .done(s1_done), .sum(s1_sum), .cout(s1_cout)
  );

  // One complete operation on the 8-bit instance: latency, hold, result, pulse width.
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic ic);
    logic [8:0] exp;
    int n;
    exp = {1'b0, ia} + {1'b0, ib} + {8'd0, ic};
    @(negedge clk);
    a = ia; b = ib; cin = ic; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        tests++;
        if (busy !== 1'b1) begin
          fails++; $display("FAIL busy_after_accept: got %b want 1", busy);
        end
        tests++;
        if ({cout, sum} !== prev_exp) begin
          fails++; $display("FAIL hold_prev: got %h want %h", {cout, sum}, prev_exp);
        end
        start = 1'b1;   // a start during busy must be ignored
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1 || n >= 40) break;
    end
    start = 1'b0;
    tests++;
    if (n != 9) begin
      fails++; $display("FAIL latency: got %0d cycles want 9", n);
    end
    tests++;
    if ({cout, sum} !== exp) begin
      fails++; $display("FAIL result a=%h b=%h cin=%b: got %h want %h", ia, ib, ic, {cout, sum}, exp);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin
      fails++; $display("FAIL done_pulse_width: got %b want 0", done);
    end
    prev_exp = exp;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    s1_start = 1'b0; s1_a = 1'b0; s1_b = 1'b0; s1_cin = 1'b0;
    #23;
    tests++;
    if ({busy, done, cout, sum} !== 11'd0) begin
      fails++; $display("FAIL reset8: got busy=%b done=%b cout=%b sum=%h want all 0", busy, done, cout, sum);
    end
    tests++;
    if ({s1_busy, s1_done, s1_cout, s1_sum} !== 4'd0) begin
      fails++; $display("FAIL reset1: got %b want 0000", {s1_busy, s1_done, s1_cout, s1_sum});
    end
    @(negedge clk);
    rst_n = 1'b1;
    prev_exp = '0;
    prev1 = '0;
  endtask

  task automatic test_basic;
    run_op(8'h03, 8'h05, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1);
  endtask

  task automatic test_width1;
    logic [1:0] exp;
    int n;
    for (int k = 0; k < 8; k++) begin
      exp = 2'(k[2]) + 2'(k[1]) + 2'(k[0]);
      @(negedge clk);
      s1_a = k[2]; s1_b = k[1]; s1_cin = k[0]; s1_start = 1'b1;
      @(posedge clk); #1;
      s1_start = 1'b0; s1_a = 1'($urandom); s1_b = 1'($urandom); s1_cin = 1'($urandom);
      n = 0;
      while (1) begin
        @(negedge clk);
        n++;
        if (n == 1) begin
          tests++;
          if ({s1_cout, s1_sum} !== prev1) begin
            fails++; $display("FAIL w1_hold: got %b want %b", {s1_cout, s1_sum}, prev1);
          end
        end
        if (s1_done === 1'b1 || n >= 20) break;
      end
      tests++;
      if (n != 2) begin
        fails++; $display("FAIL w1_latency k=%0d: got %0d want 2", k, n);
      end
      tests++;
      if ({s1_cout, s1_sum} !== exp) begin
        fails++; $display("FAIL w1_result k=%0d: got %0d want %0d", k, {s1_cout, s1_sum}, exp);
      end
      @(negedge clk);
      prev1 = exp;
    end
  endtask

  // start held high: acceptances fall every 9 edges; operands change every cycle.
  task automatic test_back_to_back;
    localparam int N = 6;
    logic [8:0] exp_q [0:9*N];
    logic [7:0] ra, rb;
    logic       rc;
    for (int j = 0; j <= 9 * N; j++) begin
      @(negedge clk);
      if (j > 0) begin
        tests++;
        if (done !== (j % 9 == 0) || busy !== (j % 9 != 0)) begin
          fails++; $display("FAIL b2b_timing j=%0d: got busy=%b done=%b want done=%b", j, busy, done, (j % 9 == 0));
        end
        if (j % 9 == 0) begin
          tests++;
          if ({cout, sum} !== exp_q[j-9]) begin
            fails++; $display("FAIL b2b_result j=%0d: got %h want %h", j, {cout, sum}, exp_q[j-9]);
          end
        end
      end
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      a = ra; b = rb; cin = rc;
      exp_q[j] = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      start = (j < 9 * N);
    end
    @(negedge clk);
    prev_exp = exp_q[9*N-9];
  endtask

  task automatic test_reset_abort;
    int seen;
    run_op(8'hFF, 8'hFF, 1'b1);
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, cout, sum} !== 11'd0) begin
      fails++; $display("FAIL reset_abort: got busy=%b done=%b cout=%b sum=%h want all 0", busy, done, cout, sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++; $display("FAIL no_done_after_abort: got %0d active cycles want 0", seen);
    end
    prev_exp = '0;
    run_op(8'h80, 8'h80, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 1000; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_width1();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
